cpu_exec_controller: RTL and testbench



---
 rtl/cpu_exec_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_cpu_exec_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_controller.sv
// cpu_exec_controller: AXI4-Lite run/halt/step/breakpoint sequencer
// that gates the DreamCode core through a clock-enable.
module cpu_exec_controller #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARSTN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [31:0]                     PC,
    input  logic [3:0]                      STAT,
    output logic                            CPU_EN,
    output logic                            HALTED
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] remaining_q, remaining_d;
    logic        skip_q, skip_d;
    logic        bp_hit_q, bp_hit_d;
    logic        bp_en_q, bp_en_d;
    logic [31:0] step_cnt_q, step_cnt_d;
    logic [31:0] bp_addr_q, bp_addr_d;
    logic [31:0] cycle_q, cycle_d;

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_fire, rd_fire;
    logic [2:0]  wr_idx, rd_idx;
    logic        cmd_wr, c_halt, c_step, c_run;
    logic        cnt_nz, bp_match, cpu_en;
    logic [31:0] rd_mux;

    assign wr_fire = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire = arready_q && S_AXI_ARVALID;
    assign wr_idx  = S_AXI_AWADDR[4:2];
    assign rd_idx  = S_AXI_ARADDR[4:2];

    // Only one command survives a write: HALT beats STEP beats RUN.
    assign cmd_wr = wr_fire && (wr_idx == 3'd0) && S_AXI_WSTRB[0];
    assign c_halt = cmd_wr && S_AXI_WDATA[1];
    assign c_step = cmd_wr && !S_AXI_WDATA[1] && S_AXI_WDATA[2];
    assign c_run  = cmd_wr && !S_AXI_WDATA[1] && !S_AXI_WDATA[2]
                    && S_AXI_WDATA[0];

    assign cnt_nz   = (step_cnt_q != 32'd0);
    assign bp_match = bp_en_q && (PC == bp_addr_q) && !skip_q;
    assign cpu_en   = ((state_q == ST_RUN) || (state_q == ST_STEP))
                      && !bp_match;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        skip_d      = skip_q;
        bp_hit_d    = bp_hit_q;
        if (cpu_en) begin
            skip_d = 1'b0;
            if (state_q == ST_STEP) remaining_d = remaining_q - 32'd1;
        end
        if (c_run || c_step) bp_hit_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (c_step && cnt_nz) begin
                    state_d     = ST_STEP;
                    remaining_d = step_cnt_q;
                end else if (c_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (c_halt) begin
                    state_d = ST_IDLE;
                end else if (bp_match) begin
                    state_d  = ST_BREAK;
                    bp_hit_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (c_halt) begin
                    state_d = ST_IDLE;
                end else if (bp_match) begin
                    state_d  = ST_BREAK;
                    bp_hit_d = 1'b1;
                end else if (c_run) begin
                    state_d = ST_RUN;
                end else if (cpu_en && remaining_q == 32'd1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BREAK: begin
                // Resume steps over the breakpointed instruction once.
                if (c_halt) begin
                    state_d = ST_IDLE;
                end else if (c_step && cnt_nz) begin
                    state_d     = ST_STEP;
                    remaining_d = step_cnt_q;
                    skip_d      = 1'b1;
                end else if (c_run) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        step_cnt_d = step_cnt_q;
        bp_addr_d  = bp_addr_q;
        bp_en_d    = bp_en_q;
        cycle_d    = cpu_en ? cycle_q + 32'd1 : cycle_q;
        if (cmd_wr) bp_en_d = S_AXI_WDATA[3];
        for (int b = 0; b < 4; b++) begin
            if (wr_fire && S_AXI_WSTRB[b]) begin
                if (wr_idx == 3'd1)
                    step_cnt_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                if (wr_idx == 3'd2)
                    bp_addr_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
        end
        if (wr_fire && wr_idx == 3'd4) cycle_d = 32'd0;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (rd_idx)
            3'd0:    rd_mux = {28'd0, bp_en_q, 3'd0};
            3'd1:    rd_mux = step_cnt_q;
            3'd2:    rd_mux = bp_addr_q;
            3'd3:    rd_mux = {24'd0, STAT, bp_hit_q, 1'b0, state_q};
            3'd4:    rd_mux = cycle_q;
            3'd5:    rd_mux = PC;
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        awready_d = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
        bvalid_d  = bvalid_q;
        if (wr_fire) bvalid_d = 1'b1;
        else if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        arready_d = S_AXI_ARVALID && !arready_q && !rvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            state_q     <= ST_IDLE;
            remaining_q <= 32'd0;
            skip_q      <= 1'b0;
            bp_hit_q    <= 1'b0;
            bp_en_q     <= 1'b0;
            step_cnt_q  <= 32'd0;
            bp_addr_q   <= 32'd0;
            cycle_q     <= 32'd0;
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            skip_q      <= skip_d;
            bp_hit_q    <= bp_hit_d;
            bp_en_q     <= bp_en_d;
            step_cnt_q  <= step_cnt_d;
            bp_addr_q   <= bp_addr_d;
            cycle_q     <= cycle_d;
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign CPU_EN        = cpu_en;
    assign HALTED        = (state_q == ST_IDLE) || (state_q == ST_BREAK);

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:5],
                         S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:5],
                         S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_cpu_exec_controller.sv
// tb_cpu_exec_controller: directed bench for cpu_exec_controller
// with a simple core model that advances PC by 4 per enabled cycle.
module tb_cpu_exec_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] pc;
    logic [3:0]  stat;
    logic        cpu_en, halted;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd4;

    cpu_exec_controller dut (
        .S_AXI_ACLK(clk), .S_AXI_ARSTN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .PC(pc), .STAT(stat), .CPU_EN(cpu_en), .HALTED(halted)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks are entered and left on a falling edge.
    task automatic wr(input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (!awready) begin
            errors++;
            $display("FAIL wr_timeout: addr=0x%04h", a);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (!rvalid) begin
            errors++;
            $display("FAIL rd_timeout: addr=0x%04h", a);
        end
        d = rdata;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        int          stall;
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; bready = 1'b1; rready = 1'b1; stat = 4'h0;
        repeat (3) @(negedge clk);

        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd1);
        check("rst_ready", {30'd0, awready, arready}, 32'd0);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rd(16'(i * 4), v);
            check($sformatf("rst_reg%0d", i), v, 32'd0);
        end

        stat = 4'hA;
        wr(16'h0004, 32'd5, 4'hF);
        wr(16'h0000, 32'h4, 4'hF);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_en) n++;
            @(negedge clk);
        end
        check("step5_en_cycles", n, 32'd5);
        rd(16'h0010, v); check("step5_cycle", v, 32'd5);
        rd(16'h000C, v); check("step5_status", v, 32'h0000_00A0);
        rd(16'h0014, v); check("step5_pc", v, 32'h14);
        check("step5_halted", {31'd0, halted}, 32'd1);

        do_reset();
        stat = 4'h0;
        wr(16'h0008, 32'h20, 4'hF);
        wr(16'h0000, 32'h9, 4'hF);
        n = 0;
        while (cpu_en && n < 100) begin @(negedge clk); n++; end
        check("bp_stop_pc", pc, 32'h20);
        @(negedge clk);
        check("bp_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("bp_halted", {31'd0, halted}, 32'd1);
        rd(16'h000C, v); check("bp_status", v, 32'h0000_000B);
        rd(16'h0000, v); check("bp_ctrl", v, 32'h8);
        rd(16'h0010, v); check("bp_cycle", v, 32'd8);
        wr(16'h0000, 32'h9, 4'hF);
        check("bp_resume_en", {31'd0, cpu_en}, 32'd1);
        repeat (3) @(negedge clk);
        check("bp_resume_pc", pc, 32'h2C);
        rd(16'h000C, v); check("bp_resume_status", v, 32'h0000_0001);
        wr(16'h0000, 32'h2, 4'hF);
        check("bp_halt", {31'd0, halted}, 32'd1);

        wr(16'h0004, 32'd2, 4'hF);
        wr(16'h0000, 32'h1, 4'hF);
        check("run_en", {31'd0, cpu_en}, 32'd1);
        wr(16'h0000, 32'h4, 4'hF);
        rd(16'h000C, v); check("step_in_run", v, 32'h0000_0001);
        wr(16'h0000, 32'h7, 4'hF);
        check("prio_halted", {31'd0, halted}, 32'd1);
        check("prio_cpu_en", {31'd0, cpu_en}, 32'd0);
        rd(16'h000C, v); check("prio_status", v, 32'h0);

        force dut.cycle_q = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.cycle_q;
        @(negedge clk);
        rd(16'h0010, v); check("wrap_preset", v, 32'hFFFF_FFFF);
        wr(16'h0004, 32'd1, 4'hF);
        wr(16'h0000, 32'h4, 4'hF);
        repeat (2) @(negedge clk);
        rd(16'h0010, v); check("wrap_zero", v, 32'd0);
        wr(16'h0000, 32'h1, 4'hF);
        repeat (4) @(negedge clk);
        wr(16'h0010, 32'hDEAD_BEEF, 4'hF);
        rd(16'h0010, v); check("clr_in_run", v, 32'd1);
        wr(16'h0000, 32'h2, 4'hF);
        rd(16'h0010, v); check("clr_resume", v, 32'd4);

        do_reset();
        wr(16'h0004, 32'hAABB_CCDD, 4'b0010);
        rd(16'h0004, v); check("wstrb_byte1", v, 32'h0000_CC00);
        wr(16'h0000, 32'h1, 4'b0010);
        check("ctrl_no_strb0", {31'd0, halted}, 32'd1);
        wr(16'h0018, 32'h1234_5678, 4'hF);
        rd(16'h0018, v); check("reg18_zero", v, 32'd0);

        awaddr = 16'h0004; wdata = 32'h1111_1111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        awaddr = 16'h0008; wdata = 32'h2222_2222;
        stall = 0;
        for (int i = 0; i < 3; i++) begin
            if (awready || !bvalid) stall++;
            @(negedge clk);
        end
        check("b2b_stall", stall, 32'd0);
        bready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (!awready) begin
            errors++;
            $display("FAIL b2b_timeout: awready never rose");
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        rd(16'h0004, v); check("b2b_first", v, 32'h1111_1111);
        rd(16'h1008, v); check("b2b_second_alias", v, 32'h2222_2222);

        wr(16'h0000, 32'h1, 4'hF);
        @(negedge clk);
        check("pre_areset_en", {31'd0, cpu_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("areset_halted", {31'd0, halted}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(16'h0004, v); check("areset_step_cnt", v, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
